// File: rtl/imm_ext_pipe_pkg.sv
// imm_ext_pipe_pkg: shared extension-op encodings and buffer constants
package imm_ext_pipe_pkg;
  localparam int EXTOP_W = 3;
  localparam int FIFO_DEPTH = 2;
  typedef enum logic [EXTOP_W-1:0] {
    EXTOP_ZERO      = 3'd0,
    EXTOP_SIGNED    = 3'd1,
    EXTOP_UPPER     = 3'd2,
    EXTOP_BR_SIGNED = 3'd3,
    EXTOP_BR_ZERO   = 3'd4,
    EXTOP_NONE      = 3'd5,
    EXTOP_RSV6      = 3'd6,
    EXTOP_RSV7      = 3'd7
  } extop_e;
endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core: combinational immediate extender shared by pipelined and single-cycle datapaths
module imm_ext_core
  import imm_ext_pipe_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic [IN_W-1:0]    imm_i,
  input  logic [EXTOP_W-1:0] op_i,
  output logic [OUT_W-1:0]   ext_o,
  output logic               err_o
);
  logic [OUT_W-1:0] zx, sx, up;
  assign zx = OUT_W'(imm_i);
  assign sx = OUT_W'($signed(imm_i));
  assign up = zx << (OUT_W - IN_W);
  // select the extension; NONE and reserved ops yield zero
  always_comb begin
    ext_o = op_i == EXTOP_ZERO      ? zx :
            op_i == EXTOP_SIGNED    ? sx :
            op_i == EXTOP_UPPER     ? up :
            op_i == EXTOP_BR_SIGNED ? sx << BR_SHIFT :
            op_i == EXTOP_BR_ZERO   ? zx << BR_SHIFT : '0;
    err_o = op_i > EXTOP_NONE;
  end
endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: extends immediates on input and buffers {err, imm} in a 2-entry FIFO
module imm_ext_pipe
  import imm_ext_pipe_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_imm,
  input  logic [EXTOP_W-1:0] in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_imm,
  output logic               out_err,
  output logic [1:0]         occupancy
);
  logic [OUT_W-1:0] ext;
  logic             err, push, pop;
  logic             wr_q, wr_d, rd_q, rd_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [OUT_W:0]   mem_q [FIFO_DEPTH];
  logic [OUT_W:0]   head;
  imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W), .BR_SHIFT(BR_SHIFT)) u_core (
    .imm_i(in_imm),
    .op_i (in_op),
    .ext_o(ext),
    .err_o(err)
  );
  assign in_ready  = !cnt_q[1];
  assign out_valid = |cnt_q;
  assign occupancy = cnt_q;
  assign head      = mem_q[rd_q];
  assign out_imm   = out_valid ? head[OUT_W-1:0] : '0;
  assign out_err   = out_valid & head[OUT_W];
  // handshake decode and next pointer/count; full blocks accept regardless of out_ready
  always_comb begin
    push  = in_valid && in_ready;
    pop   = out_valid && out_ready;
    wr_d  = wr_q ^ push;
    rd_d  = rd_q ^ pop;
    cnt_d = cnt_q + 2'(push) - 2'(pop);
  end
  // pointer and occupancy state; reset discards everything buffered
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // storage written only on accept; output is gated so empty entries never leak
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_q] <= {err, ext};
  end
endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Parametrised, pipelined immediate extender for the multicycle/pipelined datapath.
- Accepts an IN_W-bit immediate plus an extension op over a valid/ready handshake.
- Produces an OUT_W-bit extended result one cycle later, through a 2-entry output buffer, so decode-stage stalls never drop or duplicate an immediate.
- Adds upper-placement and shifted branch-offset modes, plus a per-item illegal-op flag.

Parameters:
- IN_W, 16, immediate input width; legal range 1..OUT_W.
- OUT_W, 32, extended output width.
- BR_SHIFT, 2, left-shift applied in the branch-offset modes; must satisfy IN_W+BR_SHIFT <= OUT_W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input item present
- in_ready  out  1  block can accept an input this cycle
- in_imm  in  IN_W  raw immediate
- in_op  in  3  extension op (encodings below)
- out_valid  out  1  output item present
- out_ready  in  1  consumer accepts the output this cycle
- out_imm  out  OUT_W  extended immediate
- out_err  out  1  the item at the output had a reserved op
- occupancy  out  2  number of items buffered (0..2)

Behaviour:
- Clock and reset: single clock domain, clk; rst is synchronous and active-high.
- Ops (x = in_imm):
  - 0 ZERO: zero-extend x.
  - 1 SIGNED: sign-extend from x[IN_W-1].
  - 2 UPPER: x placed at [OUT_W-1:OUT_W-IN_W], lower bits 0.
  - 3 BR_SIGNED: sign-extend x, then shift left by BR_SHIFT, truncated to OUT_W.
  - 4 BR_ZERO: zero-extend x, then shift left by BR_SHIFT.
  - 5 NONE: result 0, no error.
  - 6, 7 reserved: result 0, out_err=1.
- Extension is combinational on the input side. The result and error flag are written into a 2-entry FIFO, entry = {err, imm}.
- Transfers:
  - Accept on in_valid && in_ready.
  - Emit on out_valid && out_ready.
- in_ready = (occupancy < 2). It is driven from registered state only, with no combinational path from out_ready.
- out_valid = (occupancy != 0). out_imm and out_err reflect the head entry and are held stable while out_valid && !out_ready.
- Latency: an input accepted in cycle N is visible at the output in cycle N+1 when the buffer was empty. Sustained throughput is 1 item per cycle with out_ready held high.
- Occupancy update per cycle, by case:
  - Accept only: +1.
  - Emit only: -1.
  - Both: unchanged; head advances and the new item goes to the tail.
- Full (occupancy=2): in_ready=0. Any in_valid is ignored with no state change, even if out_ready=1 that same cycle; space frees on the next cycle.
- Empty with simultaneous accept: the item is not bypassed. out_valid rises the next cycle.
- Read/write pointers are 1 bit each and wrap modulo 2.
- Ordering: strict FIFO; items never reorder or duplicate.
- Reset values: occupancy=0, out_valid=0, in_ready=1, out_imm=0, out_err=0, pointers=0.
- Reset during traffic: all buffered items are discarded, and in_valid is ignored in the reset cycle. The output returns to the reset values on the edge where rst=1 is sampled.
- in_imm and in_op are don't-care when in_valid=0. Storage is written only on accept.

Decomposition:
- Op encodings EXTOP_ZERO .. EXTOP_NONE (3-bit) and EXTOP_W=3 belong in the shared control-encode define file, extending the existing EXTOP set. Existing values 0/1 keep their meaning; the former "instruction → 0" encoding moves to NONE=5.
- Sub-module imm_ext_core: purely combinational, parametrised by IN_W/OUT_W/BR_SHIFT. Inputs imm and op; outputs ext and err. It is instantiated once on the input side and reused by future single-cycle datapaths.

Test Plan:
- Default params, out_ready=1. Send (0x8000, SIGNED), (0x8000, ZERO), (0x1234, UPPER) -> outputs 0xFFFF8000, 0x00008000, 0x12340000 on consecutive cycles, each one cycle after its accept.
- Branch modes: (0xFFFF, BR_SIGNED) -> 0xFFFFFFFC. (0xFFFF, BR_ZERO) -> 0x0003FFFC. (0x0001, BR_SIGNED) -> 0x00000004.
- Backpressure: out_ready=0 with 3 back-to-back valid inputs (A, B, C).
  - Expected: occupancy reaches 2 and in_ready=0; C is not accepted; out_imm stays A.
  - Then raise out_ready: A, B drain in order; C is accepted once in_ready=1.
- Simultaneous push/pop at occupancy=1 for 10 cycles -> occupancy stays 1, and the output sequence equals the input sequence delayed by exactly one item.
- Reserved ops 6 and 7 with imm 0x7FFF -> out_imm=0 and out_err=1. The following (0x0001, ZERO) -> out_imm=1 and out_err=0.
- Assert rst for one cycle with 2 items buffered -> next cycle occupancy=0, out_valid=0, in_ready=1, out_imm=0; no stale item emerges afterwards.
- Param sweep IN_W=12, OUT_W=20: (0x800, SIGNED) -> 0xFF800; (0xABC, UPPER) -> 0xABC00.
